// File: rtl/dsp_bus_pkg.sv
// Shared types and helpers for the FPGA-to-DSP parallel bus master.
//   bus_state_e : bus-cycle state encoding (IDLE, SETUP, STROBE, HOLD)
//   DEF_*       : default widths and timing used by dsp_bus_master
//   ch_slice    : extracts field i of width w from a packed per-channel vector
package dsp_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } bus_state_e;

  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_N_CH        = 4;
  localparam int DEF_SETUP_CYC   = 2;
  localparam int DEF_TIMEOUT_CYC = 16;

  // Upper bounds for the generic slicer. A packed per-channel vector can be at
  // most CH_VEC_MAX bits, and a single field at most CH_FIELD_MAX bits.
  localparam int CH_VEC_MAX   = 512;
  localparam int CH_FIELD_MAX = 64;

  // Field i of width w from a zero-extended packed vector. Callers cast the
  // result back down to their own field width.
  function automatic logic [CH_FIELD_MAX-1:0] ch_slice(
    input logic [CH_VEC_MAX-1:0] vec,
    input int unsigned           i,
    input int unsigned           w
  );
    logic [CH_VEC_MAX-1:0]   shifted;
    logic [CH_FIELD_MAX-1:0] mask;
    shifted = vec >> (i * w);
    mask    = {CH_FIELD_MAX{1'b1}} >> (32'(CH_FIELD_MAX) - w);
    return shifted[CH_FIELD_MAX-1:0] & mask;
  endfunction

endpackage

// File: rtl/dsp_bus_master_if.sv
// Channel and DSP-bus signal bundle for dsp_bus_master.
//   Channel side : Req, Wr, Addr, WData (in)  / Done, Err, RData (out)
//   DSP side     : AddrBus, DataOut, DataOe, N_CS, N_DS, R_NW (out)
//                  DataIn, N_Ack (in)
//   modport master : the bus master's view
//   modport slave  : the view of whoever drives requests and models the DSP
interface dsp_bus_master_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int N_CH   = 4
);

  logic [N_CH-1:0]        Req;
  logic [N_CH-1:0]        Wr;
  logic [N_CH*ADDR_W-1:0] Addr;
  logic [N_CH*DATA_W-1:0] WData;
  logic [N_CH-1:0]        Done;
  logic                   Err;
  logic [DATA_W-1:0]      RData;

  logic [ADDR_W-1:0]      AddrBus;
  logic [DATA_W-1:0]      DataOut;
  logic                   DataOe;
  logic [DATA_W-1:0]      DataIn;
  logic                   N_CS;
  logic                   N_DS;
  logic                   R_NW;
  logic                   N_Ack;

  modport master (
    input  Req, Wr, Addr, WData, DataIn, N_Ack,
    output Done, Err, RData, AddrBus, DataOut, DataOe, N_CS, N_DS, R_NW
  );

  modport slave (
    output Req, Wr, Addr, WData, DataIn, N_Ack,
    input  Done, Err, RData, AddrBus, DataOut, DataOe, N_CS, N_DS, R_NW
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter over N_CH request lines.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   req_i         : request vector
//   adv_i         : accept the current grant and move the pointer onto it
//   gnt_o         : one-hot grant (combinational from req_i and pointer)
//   gnt_idx_o     : index of the granted channel
// The pointer holds the last served channel; the search starts just after it,
// so after reset (pointer = N_CH-1) channel 0 has top priority.
module rr_arbiter #(
  parameter int N_CH = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [N_CH-1:0]                        req_i,
  input  logic                                   adv_i,
  output logic [N_CH-1:0]                        gnt_o,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] gnt_idx_o
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [IDX_W-1:0] cand_s;
  logic [IDX_W-1:0] idx_s;
  logic [N_CH-1:0]  gnt_s;
  logic             found_s;

  // Search channels ptr+1, ptr+2, ... (wrapping) for the first request.
  always_comb begin
    gnt_s   = '0;
    idx_s   = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int k = 1; k <= N_CH; k++) begin
      cand_s = IDX_W'((32'(ptr_q) + 32'(k)) % 32'(N_CH));
      if (!found_s && req_i[cand_s]) begin
        found_s       = 1'b1;
        gnt_s[cand_s] = 1'b1;
        idx_s         = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next pointer: move onto the granted channel only when the grant is taken.
  always_comb begin
    ptr_d = ptr_q;
    if (adv_i && found_s) begin
      ptr_d = idx_s;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= IDX_W'(N_CH - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign gnt_o     = gnt_s;
  assign gnt_idx_o = idx_s;

endmodule

// File: rtl/dsp_bus_master.sv
// Multi-channel bus master for the FPGA-to-DSP parallel bus.
//   Clk     : clock, rising edge
//   N_Reset : asynchronous active-low reset
//   bus     : dsp_bus_master_if.master -- channel requests/completions and the
//             DSP strobes, address, data and acknowledge
// One bus cycle at a time: IDLE -> SETUP (SETUP_CYC) -> STROBE (until N_Ack
// low or TIMEOUT_CYC cycles) -> HOLD (1) -> IDLE. All outputs are registered.
module dsp_bus_master
  import dsp_bus_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int N_CH        = DEF_N_CH,
  parameter int SETUP_CYC   = DEF_SETUP_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              Clk,
  input  logic              N_Reset,
  dsp_bus_master_if.master  bus
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int SET_W = $clog2(SETUP_CYC + 1);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  bus_state_e        state_q;
  logic [SET_W-1:0]  setup_cnt_q;
  logic [CNT_W-1:0]  strb_cnt_q;
  logic [N_CH-1:0]   gnt_q;
  logic              wr_q;

  logic              n_cs_q;
  logic              n_ds_q;
  logic              r_nw_q;
  logic              data_oe_q;
  logic [ADDR_W-1:0] addr_bus_q;
  logic [DATA_W-1:0] data_out_q;
  logic [N_CH-1:0]   done_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;

  logic              adv_s;
  logic [N_CH-1:0]   gnt_s;
  logic [IDX_W-1:0]  gnt_idx_s;
  logic              wr_sel_s;
  logic [ADDR_W-1:0] addr_sel_s;
  logic [DATA_W-1:0] wdata_sel_s;
  logic [CH_VEC_MAX-1:0] addr_ext_s;
  logic [CH_VEC_MAX-1:0] wdata_ext_s;

  // Requests are only looked at in IDLE; an in-flight cycle is never aborted.
  assign adv_s = (state_q == IDLE) && (|bus.Req);

  rr_arbiter #(
    .N_CH (N_CH)
  ) u_arb (
    .clk_i     (Clk),
    .rst_ni    (N_Reset),
    .req_i     (bus.Req),
    .adv_i     (adv_s),
    .gnt_o     (gnt_s),
    .gnt_idx_o (gnt_idx_s)
  );

  // Select the winning channel's fields out of the packed request vectors.
  assign addr_ext_s  = CH_VEC_MAX'(bus.Addr);
  assign wdata_ext_s = CH_VEC_MAX'(bus.WData);
  assign addr_sel_s  = ADDR_W'(ch_slice(addr_ext_s, 32'(gnt_idx_s), 32'(ADDR_W)));
  assign wdata_sel_s = DATA_W'(ch_slice(wdata_ext_s, 32'(gnt_idx_s), 32'(DATA_W)));
  assign wr_sel_s    = bus.Wr[gnt_idx_s];

  // Bus-cycle FSM with all bus and completion outputs registered.
  always_ff @(posedge Clk or negedge N_Reset) begin
    if (!N_Reset) begin
      state_q     <= IDLE;
      setup_cnt_q <= '0;
      strb_cnt_q  <= '0;
      gnt_q       <= '0;
      wr_q        <= 1'b0;
      n_cs_q      <= 1'b1;
      n_ds_q      <= 1'b1;
      r_nw_q      <= 1'b1;
      data_oe_q   <= 1'b0;
      addr_bus_q  <= '0;
      data_out_q  <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= '0;
          if (adv_s) begin
            // Latch the request; later changes on the channel are ignored.
            state_q     <= SETUP;
            gnt_q       <= gnt_s;
            wr_q        <= wr_sel_s;
            n_cs_q      <= 1'b0;
            addr_bus_q  <= addr_sel_s;
            r_nw_q      <= ~wr_sel_s;
            data_out_q  <= wdata_sel_s;
            data_oe_q   <= wr_sel_s;
            setup_cnt_q <= SET_W'(1);
          end else begin
            state_q <= IDLE;
          end
        end
        SETUP: begin
          if (setup_cnt_q == SET_W'(SETUP_CYC)) begin
            state_q    <= STROBE;
            n_ds_q     <= 1'b0;
            strb_cnt_q <= CNT_W'(1);
          end else begin
            setup_cnt_q <= setup_cnt_q + SET_W'(1);
          end
        end
        STROBE: begin
          // Ack is checked first so an ack on the timeout edge still succeeds.
          if (!bus.N_Ack) begin
            state_q <= HOLD;
            n_ds_q  <= 1'b1;
            done_q  <= gnt_q;
            err_q   <= 1'b0;
            rdata_q <= wr_q ? '0 : bus.DataIn;
          end else if (strb_cnt_q == CNT_W'(TIMEOUT_CYC)) begin
            state_q <= HOLD;
            n_ds_q  <= 1'b1;
            done_q  <= gnt_q;
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else begin
            strb_cnt_q <= strb_cnt_q + CNT_W'(1);
          end
        end
        HOLD: begin
          // N_CS, address and data drive were held one cycle past N_DS.
          state_q   <= IDLE;
          done_q    <= '0;
          n_cs_q    <= 1'b1;
          r_nw_q    <= 1'b1;
          data_oe_q <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          done_q    <= '0;
          n_cs_q    <= 1'b1;
          n_ds_q    <= 1'b1;
          r_nw_q    <= 1'b1;
          data_oe_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.N_CS    = n_cs_q;
  assign bus.N_DS    = n_ds_q;
  assign bus.R_NW    = r_nw_q;
  assign bus.DataOe  = data_oe_q;
  assign bus.AddrBus = addr_bus_q;
  assign bus.DataOut = data_out_q;
  assign bus.Done    = done_q;
  assign bus.Err     = err_q;
  assign bus.RData   = rdata_q;

endmodule

// File: tb/tb_dsp_bus_master.sv
module tb_dsp_bus_master;

  logic Clk;
  logic N_Reset;

  dsp_bus_master_if #(.ADDR_W(8),  .DATA_W(8),  .N_CH(4)) bus  ();
  dsp_bus_master_if #(.ADDR_W(16), .DATA_W(32), .N_CH(3)) busb ();

  dsp_bus_master #(
    .ADDR_W(8), .DATA_W(8), .N_CH(4), .SETUP_CYC(2), .TIMEOUT_CYC(16)
  ) u_dut (
    .Clk     (Clk),
    .N_Reset (N_Reset),
    .bus     (bus)
  );

  dsp_bus_master #(
    .ADDR_W(16), .DATA_W(32), .N_CH(3), .SETUP_CYC(1), .TIMEOUT_CYC(16)
  ) u_dut_b (
    .Clk     (Clk),
    .N_Reset (N_Reset),
    .bus     (busb)
  );

  typedef struct {
    int         ch;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       err;
    logic [7:0] rdata;
    int         ncs;
    int         nds;
  } exp_t;

  exp_t exp_q[$];

  int n_chk = 0;
  int n_err = 0;
  int ack_at;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push_exp(input int ch, input logic wr, input logic [7:0] addr,
                          input logic [7:0] wdata, input logic err,
                          input logic [7:0] rdata, input int ncs, input int nds);
    exp_t e;
    e.ch = ch; e.wr = wr; e.addr = addr; e.wdata = wdata;
    e.err = err; e.rdata = rdata; e.ncs = ncs; e.nds = nds;
    exp_q.push_back(e);
  endtask

  task automatic set_ch(input int c, input logic wr, input logic [7:0] addr, input logic [7:0] wdata);
    bus.Wr[c]         = wr;
    bus.Addr[c*8 +: 8]  = addr;
    bus.WData[c*8 +: 8] = wdata;
  endtask

  // Wait for n Done pulses; unless hold is set, each served channel drops Req.
  task automatic wait_dones(input int n, input bit hold);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < 600) begin
      @(negedge Clk);
      cyc++;
      if (bus.Done != 4'b0000) begin
        seen++;
        if (!hold) bus.Req = bus.Req & ~bus.Done;
      end
    end
    if (seen < n) chk("wait_done_bound", 64'(seen), 64'(n));
  endtask

  // DSP model for the 8-bit bus: N_Ack low on strobe cycle ack_at (0 = never).
  initial begin
    int scnt;
    scnt = 0;
    bus.N_Ack = 1'b1;
    forever begin
      @(negedge Clk);
      if (!N_Reset || bus.N_DS) begin
        scnt = 0;
        bus.N_Ack = 1'b1;
      end else begin
        scnt++;
        bus.N_Ack = (ack_at != 0 && scnt >= ack_at) ? 1'b0 : 1'b1;
      end
    end
  end

  // DSP model for the wide bus: immediate acknowledge.
  initial begin
    busb.N_Ack = 1'b1;
    forever begin
      @(negedge Clk);
      busb.N_Ack = (N_Reset && !busb.N_DS) ? 1'b0 : 1'b1;
    end
  end

  // Scoreboard monitor: measures each bus cycle and compares at Done.
  initial begin
    int   ncs_cnt;
    int   nds_cnt;
    bit   seq_ok;
    bit   idle_chk;
    exp_t e;
    logic [3:0] e_done;
    ncs_cnt = 0; nds_cnt = 0; seq_ok = 1'b1; idle_chk = 1'b0;
    forever begin
      @(negedge Clk);
      if (idle_chk) begin
        chk("turnaround_ncs_high", 64'(bus.N_CS), 64'h1);
        chk("done_single_cycle", 64'(bus.Done), 64'h0);
        idle_chk = 1'b0;
      end
      if (bus.N_CS) begin
        ncs_cnt = 0; nds_cnt = 0; seq_ok = 1'b1;
      end else begin
        ncs_cnt++;
        if (!bus.N_DS) nds_cnt++;
        if (exp_q.size() > 0) begin
          e = exp_q[0];
          if (bus.AddrBus !== e.addr || bus.R_NW !== ~e.wr || bus.DataOe !== e.wr) seq_ok = 1'b0;
        end
      end
      if (bus.Done != 4'b0000) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'(bus.Done), 64'h0);
        end else begin
          e = exp_q.pop_front();
          e_done = 4'b0000;
          e_done[e.ch] = 1'b1;
          chk("done_channel", 64'(bus.Done), 64'(e_done));
          chk("err", 64'(bus.Err), 64'(e.err));
          chk("rdata", 64'(bus.RData), 64'(e.rdata));
          chk("ncs_low_cycles", 64'(ncs_cnt), 64'(e.ncs));
          chk("nds_low_cycles", 64'(nds_cnt), 64'(e.nds));
          chk("addr_rnw_oe_held", 64'(seq_ok), 64'h1);
          chk("hold_nds_high", 64'(bus.N_DS), 64'h1);
          if (e.wr) chk("dataout", 64'(bus.DataOut), 64'(e.wdata));
          idle_chk = 1'b1;
        end
      end
    end
  end

  initial begin
    int   cnt;
    bit   hit;
    N_Reset = 1'b0;
    ack_at  = 1;
    bus.Req = 4'h0; bus.Wr = 4'h0; bus.Addr = 32'h0; bus.WData = 32'h0; bus.DataIn = 8'h00;
    busb.Req = 3'b000; busb.Wr = 3'b000; busb.Addr = 48'h0; busb.WData = 96'h0; busb.DataIn = 32'h0;

    // Reset state.
    #12;
    chk("rst_ncs", 64'(bus.N_CS), 64'h1);
    chk("rst_nds", 64'(bus.N_DS), 64'h1);
    chk("rst_rnw", 64'(bus.R_NW), 64'h1);
    chk("rst_oe", 64'(bus.DataOe), 64'h0);
    chk("rst_addr", 64'(bus.AddrBus), 64'h0);
    chk("rst_dout", 64'(bus.DataOut), 64'h0);
    chk("rst_done_err_rdata", 64'({bus.Done, bus.Err, bus.RData}), 64'h0);
    @(negedge Clk);
    N_Reset = 1'b1;
    repeat (2) @(negedge Clk);

    // Round-robin with all four channels held: 0,1,2,3,0.
    for (int c = 0; c < 4; c++) set_ch(c, c[0], 8'h20 + 8'(c), 8'hC0 + 8'(c));
    bus.DataIn = 8'h99;
    ack_at = 1;
    push_exp(0, 1'b0, 8'h20, 8'hC0, 1'b0, 8'h99, 4, 1);
    push_exp(1, 1'b1, 8'h21, 8'hC1, 1'b0, 8'h00, 4, 1);
    push_exp(2, 1'b0, 8'h22, 8'hC2, 1'b0, 8'h99, 4, 1);
    push_exp(3, 1'b1, 8'h23, 8'hC3, 1'b0, 8'h00, 4, 1);
    push_exp(0, 1'b0, 8'h20, 8'hC0, 1'b0, 8'h99, 4, 1);
    bus.Req = 4'hF;
    wait_dones(5, 1'b1);
    bus.Req = 4'h0;
    repeat (3) @(negedge Clk);

    // Write on ch0 with immediate ack.
    set_ch(0, 1'b1, 8'h3C, 8'hA5);
    ack_at = 1;
    push_exp(0, 1'b1, 8'h3C, 8'hA5, 1'b0, 8'h00, 4, 1);
    bus.Req[0] = 1'b1;
    wait_dones(1, 1'b0);
    repeat (3) @(negedge Clk);

    // Read on ch2 acknowledged on the third strobe cycle.
    set_ch(2, 1'b0, 8'h10, 8'h00);
    bus.DataIn = 8'h5A;
    ack_at = 3;
    push_exp(2, 1'b0, 8'h10, 8'h00, 1'b0, 8'h5A, 6, 3);
    bus.Req[2] = 1'b1;
    wait_dones(1, 1'b0);
    repeat (3) @(negedge Clk);

    // Timeout on ch1: no ack, data bus shows junk that must not be returned.
    set_ch(1, 1'b0, 8'h77, 8'h00);
    bus.DataIn = 8'hFF;
    ack_at = 0;
    push_exp(1, 1'b0, 8'h77, 8'h00, 1'b1, 8'h00, 19, 16);
    bus.Req[1] = 1'b1;
    wait_dones(1, 1'b0);
    repeat (3) @(negedge Clk);

    // Reset in the middle of a strobe.
    set_ch(2, 1'b0, 8'h44, 8'h00);
    ack_at = 0;
    bus.Req[2] = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge Clk);
      if (!bus.N_DS) hit = 1'b1;
    end
    chk("strobe_reached_before_reset", 64'(hit), 64'h1);
    #2;
    N_Reset = 1'b0;
    #1;
    chk("async_rst_ncs", 64'(bus.N_CS), 64'h1);
    chk("async_rst_nds", 64'(bus.N_DS), 64'h1);
    chk("async_rst_rnw", 64'(bus.R_NW), 64'h1);
    chk("async_rst_oe", 64'(bus.DataOe), 64'h0);
    bus.Req = 4'h0;
    repeat (2) @(negedge Clk);
    chk("async_rst_no_done", 64'(bus.Done), 64'h0);
    N_Reset = 1'b1;
    @(negedge Clk);

    // After reset, ch0 wins over ch3.
    set_ch(0, 1'b1, 8'h01, 8'h11);
    set_ch(3, 1'b1, 8'h03, 8'h33);
    ack_at = 1;
    push_exp(0, 1'b1, 8'h01, 8'h11, 1'b0, 8'h00, 4, 1);
    push_exp(3, 1'b1, 8'h03, 8'h33, 1'b0, 8'h00, 4, 1);
    bus.Req = 4'b1001;
    wait_dones(2, 1'b0);
    repeat (3) @(negedge Clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);

    // Wide instance: ch1 read from its own packed slice.
    busb.Addr   = {16'h2222, 16'hBEEF, 16'h1111};
    busb.Wr     = 3'b000;
    busb.DataIn = 32'hDEADBEEF;
    busb.Req    = 3'b010;
    cnt = 0;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge Clk);
      if (!busb.N_CS) cnt++;
      if (busb.Done != 3'b000) hit = 1'b1;
    end
    chk("wide_done_seen", 64'(hit), 64'h1);
    chk("wide_done_channel", 64'(busb.Done), 64'h2);
    chk("wide_rdata", 64'(busb.RData), 64'hDEADBEEF);
    chk("wide_err", 64'(busb.Err), 64'h0);
    chk("wide_addrbus", 64'(busb.AddrBus), 64'hBEEF);
    chk("wide_ncs_low_cycles", 64'(cnt), 64'h3);
    chk("wide_oe", 64'(busb.DataOe), 64'h0);
    busb.Req = 3'b000;
    repeat (3) @(negedge Clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dsp_bus_master.md
Name: dsp_bus_master

Overview:
- Parametrised, multi-channel bus master for the FPGA-to-DSP parallel bus (N_CS / N_DS / R_NW strobes, address bus and bidirectional data bus).
- Arbitrates N_CH internal requesters round-robin and runs one bus cycle at a time, with programmable setup time, DSP acknowledge and strobe timeout.
- Sits on the FPGA side and replaces hand-driven modport signalling with a timed, width-generic controller.

Parameters:
- ADDR_W, 8, address bus width (bits).
- DATA_W, 8, data bus width (bits).
- N_CH, 4, number of requesting channels (>=1).
- SETUP_CYC, 2, cycles N_CS is held low with address valid before N_DS falls (>=1).
- TIMEOUT_CYC, 16, maximum strobe cycles waiting for N_Ack before an error (>=1).

Ports:
- Clk in 1: single clock, all logic on the rising edge.
- N_Reset in 1: asynchronous, active-low reset.
- Req in N_CH: per-channel request level; held until that channel's Done.
- Wr in N_CH: per-channel direction; 1 = write, 0 = read.
- Addr in N_CH*ADDR_W: per-channel address, packed with channel i at bits [i*ADDR_W +: ADDR_W].
- WData in N_CH*DATA_W: per-channel write data, packed the same way.
- Done out N_CH: one-cycle completion pulse to the granted channel.
- Err out 1: valid with Done; 1 = timeout.
- RData out DATA_W: read data, valid with Done.
- AddrBus out ADDR_W: bus address.
- DataOut out DATA_W: bus write data.
- DataOe out 1: data bus output enable.
- DataIn in DATA_W: bus read data.
- N_CS out 1: active-low chip select.
- N_DS out 1: active-low data strobe.
- R_NW out 1: 1 = read, 0 = write.
- N_Ack in 1: active-low DSP acknowledge, synchronous to Clk.

Behaviour:
- Reset values, applied immediately on N_Reset low, including mid-cycle:
  - N_CS = 1, N_DS = 1, R_NW = 1, DataOe = 0.
  - AddrBus = 0, DataOut = 0, Done = 0, Err = 0, RData = 0.
  - State = IDLE, round-robin pointer = N_CH-1, so channel 0 wins first.
- Outputs are all registered (no combinational paths from inputs).

State machine: IDLE -> SETUP -> STROBE -> HOLD -> IDLE.
- IDLE:
  - At a rising edge with any Req high, the arbiter grants the first requesting channel after the pointer (wrapping), and the pointer is updated to that channel.
  - The master latches that channel's Addr, Wr and WData; later changes to them are ignored.
  - Next state is SETUP: N_CS = 0, AddrBus = addr, R_NW = ~Wr, DataOut = wdata, DataOe = Wr.
- SETUP: lasts exactly SETUP_CYC cycles, then STROBE with N_DS = 0.
- STROBE:
  - Strobe counter starts at 1 and increments each cycle.
  - N_Ack == 0 sampled at an edge: RData <= DataIn for reads (0 for writes), Err <= 0, go to HOLD.
  - Else, counter == TIMEOUT_CYC: Err <= 1, RData <= 0, go to HOLD.
  - N_Ack low and timeout on the same edge: the ack wins, Err = 0.
- HOLD:
  - One cycle: N_DS = 1, while N_CS, AddrBus and DataOe remain asserted (data hold).
  - Done[granted] = 1 for exactly this cycle.
  - Next state is IDLE: N_CS = 1, R_NW = 1, DataOe = 0.
- Back-to-back transactions: at least one IDLE cycle with N_CS high (bus turnaround) between them.
- Bus cycle length: N_CS is low for SETUP_CYC + S + 1 cycles, where S is in 1..TIMEOUT_CYC strobe cycles.
- Req deasserted mid-transaction: the bus cycle still completes and Done still pulses; no abort.
- Req for the channel being served is not re-sampled until IDLE.
- Strobe counter width: $clog2(TIMEOUT_CYC+1).
- Packed slicing is width-generic; no width-specific constants.

Decomposition:
- Package dsp_bus_pkg holds:
  - State enum bus_state_e {IDLE, SETUP, STROBE, HOLD}.
  - Default width constants.
  - Function ch_slice(vec, i, w) for packed per-channel fields.
- Sub-module rr_arbiter (N_CH):
  - Inputs: req vector, advance enable.
  - Outputs: one-hot grant and index.
  - Holds the pointer; asynchronous active-low reset to N_CH-1.

Test Plan:
- Write, defaults: ch0 write addr 8'h3C data 8'hA5, N_Ack low on the 1st strobe cycle -> N_CS low 4 cycles, N_DS low 1 cycle, R_NW = 0, DataOe = 1 through HOLD, AddrBus 8'h3C, Done[0] one pulse, Err = 0.
- Read with wait: ch2 read addr 8'h10, DataIn 8'h5A, N_Ack low on the 3rd strobe cycle -> N_CS low 6 cycles, RData = 8'h5A with Done[2], DataOe = 0 throughout.
- Timeout: N_Ack held high -> N_DS low exactly 16 cycles, Done pulse with Err = 1 and RData = 0; bus idle next cycle.
- Round-robin: Req = 4'b1111 held, each Done followed by re-request -> grant order 0,1,2,3,0; one N_CS-high cycle between bus cycles.
- Reset mid-STROBE: N_Reset low during N_DS low -> N_CS, N_DS and R_NW go to 1 and DataOe to 0 without waiting for an edge; no Done. After release, ch0 is granted first.
- Parametrised: ADDR_W = 16, DATA_W = 32, N_CH = 3, SETUP_CYC = 1 -> ch1 read addr 16'hBEEF returns 32'hDEADBEEF on the correct packed slice; N_CS low 3 cycles with an immediate ack.
